// File: rtl/adc_frame_sequencer.sv
// Pixel readout sequencer: walks the sensor pointer, runs one ADC conversion per pixel and
// queues {sof, eol, sample} words in a first-word-fall-through FIFO.
module adc_frame_sequencer #(
  parameter int unsigned COLS          = 16,
  parameter int unsigned ROWS          = 16,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned FIFO_DEPTH    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  output logic                          startCapture,
  input  logic                          cs,
  input  logic [DATA_W-1:0]             dataout,
  output logic                          frameStart,
  output logic                          pixAdvance,
  input  logic                          rdEn,
  output logic [DATA_W+1:0]             rdData,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  input  logic                          clrOverflow,
  output logic                          busy
);

  localparam int unsigned ColW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RowW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned SetW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned WordW = DATA_W + 2;

  localparam logic [ColW-1:0]  LastCol    = ColW'(COLS - 1);
  localparam logic [RowW-1:0]  LastRow    = RowW'(ROWS - 1);
  localparam logic [SetW-1:0]  SettleLoad = SetW'(SETTLE_CYCLES - 1);
  localparam logic [AddrW:0]   FullLevel  = (AddrW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFstart = 3'd1,
    StSettle = 3'd2,
    StReq    = 3'd3,
    StWaitLo = 3'd4,
    StWaitHi = 3'd5,
    StStore  = 3'd6,
    StAdv    = 3'd7
  } state_e;

  state_e            state_q, state_d;
  logic [ColW-1:0]   col_q;
  logic [RowW-1:0]   row_q;
  logic [SetW-1:0]   settle_q;
  logic [DATA_W-1:0] sample_q;
  logic              last_pix;

  logic [WordW-1:0]  mem_q [FIFO_DEPTH];
  logic [AddrW:0]    wr_ptr_q, rd_ptr_q;
  logic              full, wr_en, rd_en, store;

  assign last_pix = (col_q == LastCol) && (row_q == LastRow);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (enable) state_d = StFstart;
      StFstart: state_d = StSettle;
      StSettle: if (settle_q == '0) state_d = StReq;
      StReq:    if (!cs) state_d = StWaitLo;
      StWaitLo: if (cs) state_d = StStore;
      StStore: begin
        if (last_pix) state_d = enable ? StFstart : StIdle;
        else          state_d = StAdv;
      end
      StAdv:    state_d = StSettle;
      default:  state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    startCapture = 1'b1;
    frameStart   = 1'b0;
    pixAdvance   = 1'b0;
    busy         = 1'b1;
    case (state_q)
      StIdle:   busy = 1'b0;
      StFstart: frameStart = 1'b1;
      StReq:    startCapture = 1'b0;
      StAdv:    pixAdvance = 1'b1;
      default:  ;
    endcase
  end

  // Pixel position, settle timer and captured sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q    <= '0;
      row_q    <= '0;
      settle_q <= '0;
      sample_q <= '0;
    end else begin
      if (state_q == StFstart) begin
        col_q <= '0;
        row_q <= '0;
      end else if (state_q == StAdv) begin
        if (col_q == LastCol) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      if (state_q == StFstart || state_q == StAdv) settle_q <= SettleLoad;
      else if (state_q == StSettle)                settle_q <= settle_q - 1'b1;
      if (state_q == StWaitLo && cs) sample_q <= dataout;
    end
  end

  assign store = (state_q == StStore);
  assign level = wr_ptr_q - rd_ptr_q;
  assign empty = (level == '0);
  assign full  = (level == FullLevel);
  // A full FIFO refuses the write even when a read frees a slot on the same edge.
  assign wr_en = store && !full;
  assign rd_en = rdEn && !empty;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= {(col_q == '0) && (row_q == '0), col_q == LastCol, sample_q};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (store && full)    overflow <= 1'b1;
      else if (clrOverflow) overflow <= 1'b0;
    end
  end

  assign rdData = empty ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];

endmodule

// File: tb/tb_adc_frame_sequencer.sv
// Randomized bench: a capture-block model feeds the sequencer, a FIFO reference model fills a
// scoreboard queue and a negedge monitor checks every popped word and the FIFO status.
module tb_adc_frame_sequencer;

  localparam int unsigned COLS   = 4;
  localparam int unsigned ROWS   = 2;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned SETTLE = 3;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned BUDGET = 3000;

  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, cs = 1'b1, rdEn = 1'b0, clrOverflow = 1'b0;
  logic [DATA_W-1:0] dataout = '0;
  logic startCapture, frameStart, pixAdvance, empty, overflow, busy;
  logic [DATA_W+1:0] rdData;
  logic [$clog2(DEPTH):0] level;

  adc_frame_sequencer #(
    .COLS(COLS), .ROWS(ROWS), .DATA_W(DATA_W), .SETTLE_CYCLES(SETTLE), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .startCapture(startCapture), .cs(cs),
    .dataout(dataout), .frameStart(frameStart), .pixAdvance(pixAdvance), .rdEn(rdEn),
    .rdData(rdData), .empty(empty), .level(level), .overflow(overflow),
    .clrOverflow(clrOverflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_total = 0, n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic timeout(input string name);
    n_total++;
    $display("FAIL %s: got timeout after %0d cycles, expected event (t=%0t)", name, BUDGET, $time);
  endtask

  // Capture block model and sensor pointer model
  typedef enum int {CIdle, CDelay, CConv} cap_e;
  cap_e cstate = CIdle;
  int dly, conv, pix = 0, negcount = 0, last_move = 0, fs_cnt = 0, pa_cnt = 0;
  logic store_stage = 1'b0, wr_pend = 1'b0;
  logic [DATA_W+1:0] stage_word, pend_word;

  always @(negedge clk) begin
    negcount++;
    if (reset) begin
      cs = 1'b1; cstate = CIdle; store_stage = 1'b0; wr_pend = 1'b0;
    end else begin
      if (frameStart) begin pix = 0; last_move = negcount; fs_cnt++; end
      if (pixAdvance) begin pix++; last_move = negcount; pa_cnt++; end
      wr_pend = store_stage; pend_word = stage_word; store_stage = 1'b0;
      case (cstate)
        CIdle: if (!startCapture) begin
          chk("settle_to_request", negcount - last_move, SETTLE + 1);
          dly = $urandom_range(0, 5);
          if (dly == 0) begin cs = 1'b0; conv = $urandom_range(2, 8); cstate = CConv; end
          else cstate = CDelay;
        end
        CDelay: begin
          chk("request_held_low", startCapture, 0);
          dly--;
          if (dly == 0) begin cs = 1'b0; conv = $urandom_range(2, 8); cstate = CConv; end
        end
        CConv: begin
          chk("request_released", startCapture, 1);
          dataout = DATA_W'($urandom);
          conv--;
          if (conv == 0) begin
            dataout = DATA_W'($urandom);
            cs = 1'b1;
            stage_word = {(pix == 0), ((pix % COLS) == COLS - 1), dataout};
            store_stage = 1'b1;
            cstate = CIdle;
          end
        end
        default: cstate = CIdle;
      endcase
    end
  end

  // FIFO reference model: bounded queue with drop-on-full and sticky overflow
  logic [DATA_W+1:0] exp_q[$];
  int model_cnt = 0;
  logic ovf_exp = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete(); model_cnt = 0; ovf_exp = 1'b0;
    end else begin
      automatic bit is_full = (model_cnt == DEPTH);
      automatic bit pop = rdEn && (model_cnt != 0);
      if (clrOverflow) ovf_exp = 1'b0;
      if (wr_pend) begin
        if (is_full) ovf_exp = 1'b1;
        else begin exp_q.push_back(pend_word); model_cnt++; end
      end
      if (pop) model_cnt--;
    end
  end

  // Monitor
  int words = 0;
  logic [DATA_W+1:0] last_word = '0;

  always @(negedge clk) begin
    if (!reset) begin
      chk("level", level, model_cnt);
      chk("empty", empty, model_cnt == 0);
      chk("overflow", overflow, ovf_exp);
      if (rdEn && !empty) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL rd_data: got word 0x%0h, expected no word available (t=%0t)",
                   rdData, $time);
        end else begin
          chk("rd_data", rdData, exp_q.pop_front());
        end
        words++;
        last_word = rdData;
      end
    end
  end

  // Read driver: 0 none, 1 random, 2 always; rd_manual overrides
  int rd_mode = 0;
  logic rd_manual = 1'b0, rd_force = 1'b0;
  always @(posedge clk) begin
    #2;
    if (rd_manual)         rdEn = rd_force;
    else if (rd_mode == 0) rdEn = 1'b0;
    else if (rd_mode == 1) rdEn = ($urandom_range(0, 3) != 0);
    else                   rdEn = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_enable();
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  task automatic wait_done(input int fs_target, input string name);
    int t = 0;
    while (!(fs_cnt >= fs_target && busy == 1'b0) && t < BUDGET) begin tick(); t++; end
    if (t >= BUDGET) timeout(name);
  endtask

  task automatic drain(input string name);
    int t = 0;
    rd_mode = 2;
    while (model_cnt != 0 && t < BUDGET) begin tick(); t++; end
    if (t >= BUDGET) timeout(name);
    tick();
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_startCapture"}, startCapture, 1);
    chk({tag, "_frameStart"}, frameStart, 0);
    chk({tag, "_pixAdvance"}, pixAdvance, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_rdData"}, rdData, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected end of run (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int fs0, pa0, w0, t;
    #1;
    reset_checks("reset");
    tick(); tick();
    reset = 1'b0;
    tick();

    // Single frame, random reads
    fs0 = fs_cnt; pa0 = pa_cnt; w0 = words;
    rd_mode = 1;
    pulse_enable();
    wait_done(fs0 + 1, "single_frame_done");
    drain("single_frame_drain");
    chk("single_words", words - w0, COLS * ROWS);
    chk("single_frameStarts", fs_cnt - fs0, 1);
    chk("single_pixAdvances", pa_cnt - pa0, COLS * ROWS - 1);
    chk("single_idle", busy, 0);

    // Overflow: no reads
    fs0 = fs_cnt; w0 = words;
    rd_mode = 0;
    pulse_enable();
    wait_done(fs0 + 1, "overflow_frame_done");
    chk("overflow_level_sat", level, DEPTH);
    chk("overflow_flag", overflow, 1);
    drain("overflow_drain");
    chk("overflow_words", words - w0, DEPTH);
    clrOverflow = 1'b1;
    tick();
    clrOverflow = 1'b0;
    chk("overflow_cleared", overflow, 0);

    // Continuous run, enable dropped during pixel 5 of frame 2
    fs0 = fs_cnt; pa0 = pa_cnt; w0 = words;
    rd_mode = 1;
    enable = 1'b1;
    t = 0;
    while (pa_cnt - pa0 < (COLS * ROWS - 1) + 5 && t < BUDGET) begin tick(); t++; end
    if (t >= BUDGET) timeout("continuous_pixel5");
    enable = 1'b0;
    wait_done(fs0 + 2, "continuous_done");
    drain("continuous_drain");
    chk("continuous_frames", fs_cnt - fs0, 2);
    chk("continuous_words", words - w0, 2 * COLS * ROWS);
    chk("continuous_idle", busy, 0);

    // Reset while a conversion is in flight
    rd_mode = 2;
    enable = 1'b1;
    t = 0;
    while (cs != 1'b0 && t < BUDGET) begin tick(); t++; end
    if (t >= BUDGET) timeout("reset_wait_conv");
    #2;
    reset = 1'b1;
    #1;
    reset_checks("midreset");
    tick(); tick();
    reset = 1'b0;
    w0 = words;
    t = 0;
    while (words == w0 && t < BUDGET) begin tick(); t++; end
    if (t >= BUDGET) timeout("post_reset_word");
    chk("post_reset_sof", last_word[DATA_W+1], 1);
    enable = 1'b0;
    t = 0;
    while (busy && t < BUDGET) begin tick(); t++; end
    if (t >= BUDGET) timeout("post_reset_idle");
    drain("post_reset_drain");

    // Read coinciding with STORE at level 2
    fs0 = fs_cnt; w0 = words;
    rd_mode = 0;
    pulse_enable();
    t = 0;
    while (model_cnt != 2 && t < BUDGET) begin tick(); t++; end
    if (t >= BUDGET) timeout("collision_level2");
    t = 0;
    while (!store_stage && t < BUDGET) begin tick(); t++; end
    if (t >= BUDGET) timeout("collision_store");
    rd_force = 1'b1;
    rd_manual = 1'b1;
    tick();
    rd_manual = 1'b0;
    chk("collision_level", level, 2);
    chk("collision_one_read", words - w0, 1);
    rd_mode = 2;
    wait_done(fs0 + 1, "collision_done");
    drain("collision_drain");
    chk("collision_words", words - w0, COLS * ROWS);
    chk("final_overflow", overflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
